// File: rtl/kernel_mem_responder_if.sv
// Host memory request/response bus between the accelerator wrapper (master)
// and the memory-side responder (slave).
interface kernel_mem_responder_if #(
    parameter int unsigned DATA_WID = 32
);
    logic                read_enable;
    logic [63:0]         read_addr;
    logic [63:0]         read_size;
    logic                write_enable;
    logic [63:0]         write_addr;
    logic [63:0]         write_size;
    logic [DATA_WID-1:0] write_data;
    logic [63:0]         read_ready;
    logic [DATA_WID-1:0] read_data;
    logic [63:0]         write_ready;

    modport master (
        output read_enable, read_addr, read_size,
        output write_enable, write_addr, write_size, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_enable, read_addr, read_size,
        input  write_enable, write_addr, write_size, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/kernel_mem_responder.sv
// Fixed-latency single-word memory responder backed by a scratchpad RAM, with a
// backdoor preload/dump port, sticky protocol-error flags and access counters.
module kernel_mem_responder #(
    parameter int unsigned DATA_WID = 32,
    parameter int unsigned ADDR_WID = 14,
    parameter int unsigned LATENCY  = 4,
    parameter logic [63:0] MEM_BASE = 64'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    kernel_mem_responder_if.slave bus,
    input  logic                 bd_en,
    input  logic                 bd_we,
    input  logic [ADDR_WID-1:0]  bd_addr,
    input  logic [DATA_WID-1:0]  bd_wdata,
    output logic [DATA_WID-1:0]  bd_rdata,
    output logic                 busy,
    output logic [3:0]           err_flags,
    input  logic                 stat_clear,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WID;
    localparam logic [7:0]  LAT_INIT = 8'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RD_RESP,
        WR_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            latCnt_q, latCnt_d;
    logic [ADDR_WID-1:0]   idx_q;
    logic                  oor_q;
    logic [DATA_WID-1:0]   wdata_q;
    logic [DATA_WID-1:0]   readData_q;
    logic [DATA_WID-1:0]   bdRdata_q;
    logic [3:0]            errFlags_q, errFlags_d;
    logic [31:0]           rdCount_q, rdCount_d;
    logic [31:0]           wrCount_q, wrCount_d;

    logic [DATA_WID-1:0]   mem [0:DEPTH-1];

    logic                  isIdle;
    logic                  anyStrobe;
    logic                  acceptWr;
    logic                  acceptRd;
    logic                  acceptAny;
    logic                  bdOk;
    logic                  dropEvt;
    logic                  rdDue;
    logic                  wrDue;
    logic [63:0]           reqAddr;
    logic [63:0]           reqSize;
    logic [61:0]           offsetWord;
    logic [ADDR_WID-1:0]   reqIdx;
    logic                  reqOor;

    // When both strobes arrive together the write wins, so its address is decoded.
    always_comb begin
        isIdle     = (state_q == IDLE);
        anyStrobe  = bus.read_enable | bus.write_enable;
        acceptWr   = isIdle & bus.write_enable;
        acceptRd   = isIdle & bus.read_enable & ~bus.write_enable;
        acceptAny  = acceptWr | acceptRd;
        bdOk       = isIdle & bd_en & ~anyStrobe;
        dropEvt    = (anyStrobe & ~isIdle)
                   | (isIdle & bus.read_enable & bus.write_enable)
                   | (bd_en & ~bdOk);
        rdDue      = (state_q == RD_WAIT) && (latCnt_q == 8'd0);
        wrDue      = (state_q == WR_WAIT) && (latCnt_q == 8'd0);
        reqAddr    = bus.write_enable ? bus.write_addr : bus.read_addr;
        reqSize    = bus.write_enable ? bus.write_size : bus.read_size;
        offsetWord = 62'((reqAddr - MEM_BASE) >> 2);
        reqIdx     = offsetWord[ADDR_WID-1:0];
        reqOor     = (reqAddr < MEM_BASE) || (|offsetWord[61:ADDR_WID]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            latCnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            latCnt_q <= latCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        latCnt_d = latCnt_q;
        unique case (state_q)
            IDLE: begin
                if (acceptWr) begin
                    state_d  = WR_WAIT;
                    latCnt_d = LAT_INIT;
                end else if (acceptRd) begin
                    state_d  = RD_WAIT;
                    latCnt_d = LAT_INIT;
                end
            end
            RD_WAIT: begin
                if (latCnt_q == 8'd0) state_d = RD_RESP;
                else latCnt_d = latCnt_q - 8'd1;
            end
            WR_WAIT: begin
                if (latCnt_q == 8'd0) state_d = WR_RESP;
                else latCnt_d = latCnt_q - 8'd1;
            end
            RD_RESP: state_d = IDLE;
            WR_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.read_ready  = {63'd0, state_q == RD_RESP};
        bus.write_ready = {63'd0, state_q == WR_RESP};
        bus.read_data   = readData_q;
        busy            = (state_q != IDLE);
        bd_rdata        = bdRdata_q;
        err_flags       = errFlags_q;
        rd_count        = rdCount_q;
        wr_count        = wrCount_q;
    end

    // A clear in the same cycle as an error or an increment takes priority.
    always_comb begin
        errFlags_d = errFlags_q | {dropEvt,
                                   acceptAny & (reqSize != 64'd4),
                                   acceptAny & (reqAddr[1:0] != 2'b00),
                                   acceptAny & reqOor};
        rdCount_d  = rdCount_q;
        wrCount_d  = wrCount_q;
        if (acceptRd && rdCount_q != 32'hFFFF_FFFF) rdCount_d = rdCount_q + 32'd1;
        if (acceptWr && wrCount_q != 32'hFFFF_FFFF) wrCount_d = wrCount_q + 32'd1;
        if (stat_clear) begin
            errFlags_d = 4'd0;
            rdCount_d  = 32'd0;
            wrCount_d  = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            oor_q      <= 1'b0;
            wdata_q    <= '0;
            readData_q <= '0;
            bdRdata_q  <= '0;
            errFlags_q <= 4'd0;
            rdCount_q  <= 32'd0;
            wrCount_q  <= 32'd0;
        end else begin
            if (acceptAny) begin
                idx_q <= reqIdx;
                oor_q <= reqOor;
            end
            if (acceptWr) wdata_q <= bus.write_data;
            if (rdDue) readData_q <= oor_q ? '0 : mem[idx_q];
            if (bdOk && !bd_we) bdRdata_q <= mem[bd_addr];
            errFlags_q <= errFlags_d;
            rdCount_q  <= rdCount_d;
            wrCount_q  <= wrCount_d;
        end
    end

    // The RAM itself is never reset; a reset mid-request leaves state IDLE so nothing commits.
    always_ff @(posedge clk) begin
        if (wrDue && !oor_q) mem[idx_q] <= wdata_q;
        else if (bdOk && bd_we) mem[bd_addr] <= bd_wdata;
    end

endmodule

// File: tb/tb_kernel_mem_responder.sv
// Testbench for kernel_mem_responder: vector table through a ready-pulse
// scoreboard plus hand-written multi-cycle sequences.
module tb_kernel_mem_responder;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bd_en, bd_we, stat_clear;
    logic [13:0] bd_addr;
    logic [31:0] bd_wdata, bd_rdata;
    logic        busy;
    logic [3:0]  err_flags;
    logic [31:0] rd_count, wr_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          isWrite;
        logic [31:0] data;
        int          dueCyc;
    } exp_t;

    exp_t sbQ[$];

    typedef struct {
        bit          isWrite;
        logic [63:0] addr;
        logic [63:0] size;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic [3:0]  expErr;
        logic [31:0] expRd;
        logic [31:0] expWr;
    } vec_t;

    vec_t vecs[6];

    kernel_mem_responder_if #(.DATA_WID(32)) bus ();

    kernel_mem_responder #(
        .DATA_WID(32),
        .ADDR_WID(14),
        .LATENCY (LAT),
        .MEM_BASE(64'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .bd_en     (bd_en),
        .bd_we     (bd_we),
        .bd_addr   (bd_addr),
        .bd_wdata  (bd_wdata),
        .bd_rdata  (bd_rdata),
        .busy      (busy),
        .err_flags (err_flags),
        .stat_clear(stat_clear),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every ready pulse must match the oldest outstanding expectation, on its exact cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && (bus.read_ready != 64'd0 || bus.write_ready != 64'd0)) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_ready", {bus.read_ready[31:0], bus.write_ready[31:0]}, 64'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("write_ready", bus.write_ready, e.isWrite ? 64'd1 : 64'd0);
                checkOutput("read_ready", bus.read_ready, e.isWrite ? 64'd0 : 64'd1);
                checkOutput("ready_cycle", 64'(cyc), 64'(e.dueCyc));
                if (!e.isWrite) checkOutput("read_data", {32'd0, bus.read_data}, {32'd0, e.data});
            end
        end
    end

    task automatic applyStimulus(input bit doWrite, input bit doRead, input logic [63:0] addr,
                                 input logic [63:0] size, input logic [31:0] wdata,
                                 input logic [31:0] expData, input bit expectResp);
        exp_t e;
        @(negedge clk);
        bus.write_enable = doWrite;
        bus.write_addr   = addr;
        bus.write_size   = size;
        bus.write_data   = wdata;
        bus.read_enable  = doRead;
        bus.read_addr    = addr;
        bus.read_size    = size;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        if (expectResp) begin
            e.isWrite = doWrite;
            e.data    = expData;
            e.dueCyc  = cyc + LAT;
            sbQ.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 30) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
            sbQ.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic bdWrite(input logic [13:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_en    = 1'b1;
        bd_we    = 1'b1;
        bd_addr  = idx;
        bd_wdata = data;
        @(negedge clk);
        bd_en = 1'b0;
        bd_we = 1'b0;
    endtask

    task automatic bdRead(input logic [13:0] idx, output logic [31:0] data);
        @(negedge clk);
        bd_en   = 1'b1;
        bd_we   = 1'b0;
        bd_addr = idx;
        @(posedge clk);
        #1;
        data  = bd_rdata;
        bd_en = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rdv;

        vecs[0] = '{1'b0, 64'd20,    64'd4, 32'h0,        32'hCAFE0001, 4'b0000, 32'd1, 32'd0};
        vecs[1] = '{1'b1, 64'd40,    64'd4, 32'h12345678, 32'h0,        4'b0000, 32'd1, 32'd1};
        vecs[2] = '{1'b0, 64'd40,    64'd4, 32'h0,        32'h12345678, 4'b0000, 32'd2, 32'd1};
        vecs[3] = '{1'b0, 64'd65536, 64'd4, 32'h0,        32'h0,        4'b0001, 32'd3, 32'd1};
        vecs[4] = '{1'b1, 64'd65536, 64'd4, 32'hDEADBEEF, 32'h0,        4'b0001, 32'd3, 32'd2};
        vecs[5] = '{1'b0, 64'd6,     64'd2, 32'h0,        32'hA5A50001, 4'b0111, 32'd4, 32'd2};

        reset            = 1'b1;
        bus.read_enable  = 1'b0;
        bus.read_addr    = 64'd0;
        bus.read_size    = 64'd0;
        bus.write_enable = 1'b0;
        bus.write_addr   = 64'd0;
        bus.write_size   = 64'd0;
        bus.write_data   = 32'd0;
        bd_en            = 1'b0;
        bd_we            = 1'b0;
        bd_addr          = 14'd0;
        bd_wdata         = 32'd0;
        stat_clear       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_read_ready", bus.read_ready, 64'd0);
        checkOutput("rst_write_ready", bus.write_ready, 64'd0);
        checkOutput("rst_read_data", {32'd0, bus.read_data}, 64'd0);
        checkOutput("rst_bd_rdata", {32'd0, bd_rdata}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_err_flags", {60'd0, err_flags}, 64'd0);
        checkOutput("rst_rd_count", {32'd0, rd_count}, 64'd0);
        checkOutput("rst_wr_count", {32'd0, wr_count}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        bdWrite(14'd5, 32'hCAFE0001);
        bdWrite(14'd1, 32'hA5A50001);
        bdWrite(14'd0, 32'h0BAD0BAD);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].isWrite, !vecs[i].isWrite, vecs[i].addr, vecs[i].size,
                          vecs[i].wdata, vecs[i].expData, 1'b1);
            checkOutput($sformatf("busy_vec%0d", i), {63'd0, busy}, 64'd1);
            waitDrain();
            checkOutput($sformatf("err_vec%0d", i), {60'd0, err_flags}, {60'd0, vecs[i].expErr});
            checkOutput($sformatf("rd_count_vec%0d", i), {32'd0, rd_count}, {32'd0, vecs[i].expRd});
            checkOutput($sformatf("wr_count_vec%0d", i), {32'd0, wr_count}, {32'd0, vecs[i].expWr});
        end

        bdRead(14'd10, rdv);
        checkOutput("bd_read_idx10", {32'd0, rdv}, 64'h12345678);
        bdRead(14'd0, rdv);
        checkOutput("oor_write_discarded", {32'd0, rdv}, 64'h0BAD0BAD);

        pulseClear();
        checkOutput("clear_err", {60'd0, err_flags}, 64'd0);
        checkOutput("clear_rd_count", {32'd0, rd_count}, 64'd0);
        checkOutput("clear_wr_count", {32'd0, wr_count}, 64'd0);

        // Both strobes together: only the write is serviced.
        applyStimulus(1'b1, 1'b1, 64'd8, 64'd4, 32'd7, 32'd0, 1'b1);
        waitDrain();
        checkOutput("dual_err", {60'd0, err_flags}, 64'b1000);
        checkOutput("dual_rd_count", {32'd0, rd_count}, 64'd0);
        checkOutput("dual_wr_count", {32'd0, wr_count}, 64'd1);
        bdRead(14'd2, rdv);
        checkOutput("dual_ram2", {32'd0, rdv}, 64'd7);

        pulseClear();

        // A write strobe during RD_WAIT is dropped and must not produce a second pulse.
        applyStimulus(1'b0, 1'b1, 64'd20, 64'd4, 32'd0, 32'hCAFE0001, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'd40, 64'd4, 32'hFFFFFFFF, 32'd0, 1'b0);
        waitDrain();
        repeat (4) @(posedge clk);
        checkOutput("busy_strobe_err", {60'd0, err_flags}, 64'b1000);
        checkOutput("busy_strobe_rd_count", {32'd0, rd_count}, 64'd1);
        checkOutput("busy_strobe_wr_count", {32'd0, wr_count}, 64'd0);
        bdRead(14'd10, rdv);
        checkOutput("busy_strobe_ram10", {32'd0, rdv}, 64'h12345678);

        // Reset two cycles into WR_WAIT abandons the write.
        bdWrite(14'd12, 32'h55AA0055);
        applyStimulus(1'b1, 1'b0, 64'd48, 64'd4, 32'hFFFF0000, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_read_ready", bus.read_ready, 64'd0);
        checkOutput("midrst_write_ready", bus.write_ready, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        checkOutput("midrst_err", {60'd0, err_flags}, 64'd0);
        bdRead(14'd12, rdv);
        checkOutput("midrst_ram12", {32'd0, rdv}, 64'h55AA0055);
        applyStimulus(1'b0, 1'b1, 64'd48, 64'd4, 32'd0, 32'h55AA0055, 1'b1);
        waitDrain();
        checkOutput("midrst_rd_count", {32'd0, rd_count}, 64'd1);
        checkOutput("midrst_wr_count", {32'd0, wr_count}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
